// File: rtl/cmd_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// cmd_fifo_arbiter
//   Shares the single 16-bit command-FIFO write port between N_REQ requesters.
//   Requesters are granted round-robin, one word at a time. A word whose
//   command byte is OPEN_CMD locks the grant to its owner until the owner
//   sends CLOSE_CMD, so bus transactions from different requesters never
//   interleave. A lock whose owner stays silent for TIMEOUT cycles is
//   force-released and the sticky o_timeout_err flag is raised.
//
// Handshake: requester i transfers a word in every cycle where
//   i_req_valid[i] && o_req_ready[i]. o_req_ready is only ever raised for the
//   registered owner and only while the FIFO is not full, so at most one word
//   is pushed per cycle. A requester keeps its word stable until it is taken.
//
// Ports:
//   i_clock, i_reset       clock, asynchronous active-high reset
//   i_req_valid[N_REQ]     requester i offers a word
//   i_req_data[16*N_REQ]   flat words; bits 15:8 command, 7:0 data
//   o_req_ready[N_REQ]     word of requester i accepted this cycle
//   i_fifo_full            command FIFO cannot accept a push
//   o_fifo_push/o_fifo_data  push strobe and word to the command FIFO
//   o_grant[N_REQ]         one-hot current owner, zero when idle
//   o_locked               a transaction lock is held
//   o_timeout_err          sticky, set on forced release
//   i_err_clear            clears o_timeout_err (a same-cycle timeout wins)
//   o_state                arbiter FSM state for debug (0 idle, 1 owned, 2 locked)
// ----------------------------------------------------------------------------
module cmd_fifo_arbiter #(
  parameter int          N_REQ     = 2,
  parameter logic [7:0]  OPEN_CMD  = 8'h01,
  parameter logic [7:0]  CLOSE_CMD = 8'h02,
  parameter int          TIMEOUT   = 1000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [16*N_REQ-1:0]  i_req_data,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic                 i_fifo_full,
  output logic                 o_fifo_push,
  output logic [15:0]          o_fifo_data,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_locked,
  output logic                 o_timeout_err,
  input  logic                 i_err_clear,
  output logic [1:0]           o_state
);

  localparam int          IW        = (N_REQ > 2) ? 2 : 1;
  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]    r_last, w_last_nxt;
  logic [15:0]      r_idle_cnt, w_idle_cnt_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;

  logic [IW-1:0]    w_owner;
  logic             w_owner_valid;
  logic [15:0]      w_owner_data;
  logic             w_accept;
  logic [7:0]       w_cmd;
  logic [IW-1:0]    w_pick;
  logic             w_pick_found;
  logic [N_REQ-1:0] w_pick_onehot;
  logic [15:0]      w_idle_cnt_inc;
  logic             w_timeout_hit;

  // Decode the one-hot grant into an owner index and its word.
  always_comb begin
    w_owner       = '0;
    w_owner_valid = 1'b0;
    w_owner_data  = 16'h0000;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner       = IW'(i);
        w_owner_valid = i_req_valid[i];
        w_owner_data  = i_req_data[16*i +: 16];
      end
    end
  end

  assign o_req_ready = r_grant & {N_REQ{~i_fifo_full}};
  assign w_accept    = |(i_req_valid & o_req_ready);
  assign o_fifo_push = w_accept;
  assign o_fifo_data = w_owner_data;
  assign w_cmd       = w_owner_data[15:8];

  // Round-robin pick: first valid requester scanning from r_last+1.
  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_pick_found && (i == (int'(r_last) + k) % N_REQ) && i_req_valid[i]) begin
          w_pick_found = 1'b1;
          w_pick       = IW'(i);
        end
      end
    end
  end

  assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;

  // Saturating idle counter; the release fires on the cycle whose increment
  // would bring the count to TIMEOUT.
  assign w_idle_cnt_inc = (r_idle_cnt == 16'hFFFF) ? r_idle_cnt : r_idle_cnt + 16'd1;
  assign w_timeout_hit  = ({1'b0, r_idle_cnt} + 17'd1) >= TIMEOUT_W;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_last_nxt        = r_last;
    w_idle_cnt_nxt    = r_idle_cnt;
    w_timeout_err_nxt = i_err_clear ? 1'b0 : r_timeout_err;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_grant_nxt = w_pick_onehot;
          w_state_nxt = ST_OWNED;
        end
      end

      ST_OWNED: begin
        if (w_accept) begin
          if (w_cmd == OPEN_CMD) begin
            w_state_nxt    = ST_LOCKED;
            w_idle_cnt_nxt = 16'd0;
          end else begin
            w_grant_nxt = '0;
            w_last_nxt  = w_owner;
            w_state_nxt = ST_IDLE;
          end
        end else if (!w_owner_valid) begin
          // Owner withdrew before being served: give up the slot, keep priority order.
          w_grant_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LOCKED: begin
        if (w_accept) begin
          w_idle_cnt_nxt = 16'd0;
          if (w_cmd == CLOSE_CMD) begin
            w_grant_nxt = '0;
            w_last_nxt  = w_owner;
            w_state_nxt = ST_IDLE;
          end
        end else if (!w_owner_valid) begin
          if (w_timeout_hit) begin
            w_grant_nxt       = '0;
            w_last_nxt        = w_owner;
            w_state_nxt       = ST_IDLE;
            w_timeout_err_nxt = 1'b1;
          end else begin
            w_idle_cnt_nxt = w_idle_cnt_inc;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last        <= IW'(N_REQ - 1);
      r_idle_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last        <= w_last_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_locked      = (r_state == ST_LOCKED);
  assign o_timeout_err = r_timeout_err;
  assign o_state       = r_state;

endmodule

// File: doc/cmd_fifo_arbiter.md
Name: cmd_fifo_arbiter

Overview:
- Shares the single 16-bit command-FIFO write port between N_REQ requesters, e.g. the host interface and the macro/script engine.
- Sits upstream of the command FIFO that feeds the dispatcher.
- Grants round-robin, one word at a time.
- Locks the grant to one requester across a bus transaction, from the "[" command word to the "]" command word, so transactions from different requesters never interleave.
- Forces a stalled lock to release after a programmable idle timeout.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- OPEN_CMD, 8'h01, command byte (bits 15:8) that opens a locked transaction ("[").
- CLOSE_CMD, 8'h02, command byte that closes a locked transaction ("]").
- TIMEOUT, 1000, idle cycles allowed inside a lock before forced release; legal range 1..65535.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i has a word on req_data[16*i+15:16*i]
- req_data  in  16*N_REQ  flat command words; bits 15:8 command, bits 7:0 data
- req_ready  out  N_REQ  word of requester i accepted this cycle when req_valid[i] && req_ready[i]
- fifo_full  in  1  command FIFO cannot accept a push
- fifo_push  out  1  push strobe to command FIFO
- fifo_data  out  16  word to command FIFO
- grant  out  N_REQ  one-hot current owner; all zero when idle
- locked  out  1  a transaction lock is held
- timeout_err  out  1  sticky; set on forced release
- err_clear  in  1  clears timeout_err

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, grant=0, locked=0, timeout_err=0, req_ready=0, fifo_push=0.
  - last-served pointer = N_REQ-1, so requester 0 wins first.
  - idle counter = 0.
- Handshake (combinational from registered grant):
  - req_ready[i] = grant[i] && !fifo_full.
  - fifo_push = OR over i of (req_valid[i] && req_ready[i]).
  - fifo_data = req_data slice of the granted requester; fifo_data = 0 when grant==0.
  - Never more than one push per cycle.
- States:
  - IDLE: if any req_valid, register grant to the first valid requester scanning from last+1 modulo N_REQ. One cycle arbitration latency, so the earliest push is the cycle after the request is seen. Go to OWNED.
  - OWNED (unlocked): on an accepted word:
    - command==OPEN_CMD: locked<=1, go to LOCKED, grant unchanged.
    - any other command: grant<=0, last<=owner, go to IDLE.
    - If the owner drops req_valid before any accept: release to IDLE, last unchanged.
  - LOCKED: only the owner is served. On an accepted word:
    - command==CLOSE_CMD: locked<=0, grant<=0, last<=owner, go to IDLE.
    - command==OPEN_CMD: treated as ordinary data; no nesting.
- Idle timeout (LOCKED only):
  - idle counter resets to 0 on every accepted word and on entry to LOCKED.
  - It increments only in cycles with owner req_valid=0. Cycles stalled by fifo_full do not count.
  - When the counter reaches TIMEOUT: release (grant<=0, locked<=0, last<=owner, go to IDLE) and set timeout_err<=1. No word is injected into the FIFO.
  - Counter width is 16 bits; it saturates and never wraps.
- timeout_err:
  - err_clear=1 clears it the next edge.
  - If a timeout and err_clear occur in the same cycle, set wins.
- fifo_full asserted while granted:
  - No accept, grant held, state held.
  - The data word must be held stable by the requester, per the valid/ready rule.
- Simultaneous requests: losers see req_ready=0 until granted. Round-robin guarantees each waiting requester is served within N_REQ-1 grants, excluding locks.

Test Plan:
- Reset then req_valid=2'b11, both streaming command 8'h00 words, fifo_full=0 -> pushes alternate req0, req1, req0, ... Each push is preceded by one arbitration cycle. First word out is from req0.
- Req1 sends 16'h0100, 16'h0055, 16'h0200 while req0 is continuously valid -> FIFO receives the three req1 words contiguously. locked=1 from the cycle after the 0x0100 accept until the cycle after the 0x0200 accept. Req0 is served next.
- fifo_full=1 for 5 cycles while req0 is granted and valid -> no push, req_ready=0, grant stays 01. The word pushes on the first cycle fifo_full=0.
- TIMEOUT=8: req0 sends 16'h0100 then drops valid -> forced release exactly 8 cycles later; timeout_err=1 and grant=0. Pending req1 is granted on the next cycle.
- Assert reset mid-lock with fifo_push active -> all outputs return to reset values asynchronously. After release, req0 has priority.
- err_clear pulsed during the same cycle as a second timeout -> timeout_err remains 1. A later lone err_clear clears it.
